// File: rtl/frame_blit_sequencer.sv
// frame_blit_sequencer: copies one source frame into VRAM at 1 word/clk, pulses GPU_DRAW, and applies keyboard frame/auto-animate commands
module frame_blit_sequencer #(
  parameter int DATA_W = 16,
  parameter int FRAME_AW = 10,
  parameter int NUM_FRAMES = 4,
  parameter int VRAM_AW = 16,
  parameter int AUTO_PERIOD = 60,
  localparam int FSEL_W = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1,
  localparam int SRC_AW = FSEL_W + FRAME_AW
) (
  input  logic              CLK,
  input  logic              IN_PB_RESET,
  output logic              SRC_EN,
  output logic [SRC_AW-1:0] SRC_ADDR,
  input  logic [DATA_W-1:0] SRC_DATA,
  output logic              VRAM_EN,
  output logic              VRAM_WRITE,
  output logic [VRAM_AW-1:0] VRAM_ADDR,
  output logic [DATA_W-1:0] VRAM_DATA_W,
  input  logic              GPU_READY,
  output logic              GPU_DRAW,
  input  logic              KEY_IRQ,
  output logic              KEY_IACK,
  output logic              KEY_EN,
  input  logic [15:0]       KEY_DATA,
  output logic              KEY_IEND,
  output logic [FSEL_W-1:0] CUR_FRAME,
  output logic              AUTO_MODE
);
  localparam int CNT_W = $clog2(AUTO_PERIOD + 1);
  localparam logic [FSEL_W-1:0] LAST_FRAME = FSEL_W'(NUM_FRAMES - 1);

  typedef enum logic [2:0] {WAIT, COPY, FLUSH, DRAW, KACK, KRD, KLAT, KDEC} stateType;

  stateType state;
  logic [FSEL_W-1:0] srcFrame;
  logic [FRAME_AW-1:0] srcIdx;
  logic [FRAME_AW-1:0] vramIdx;
  logic [CNT_W-1:0] drawCount;
  logic [15:0] keyCode;
  logic isDigit;
  logic [FSEL_W-1:0] digitFrame;
  logic [FSEL_W-1:0] frameNext;
  logic [FSEL_W-1:0] framePrev;

  assign SRC_ADDR = {srcFrame, srcIdx};
  assign VRAM_ADDR = VRAM_AW'(vramIdx);
  assign VRAM_WRITE = VRAM_EN;
  assign VRAM_DATA_W = SRC_DATA;

  // Explicit wrap compares keep non-power-of-2 frame counts correct
  always_comb begin
    isDigit = keyCode >= 16'h31 && keyCode < 16'(16'h31 + NUM_FRAMES);
    digitFrame = FSEL_W'(keyCode - 16'h31);
    frameNext = CUR_FRAME == LAST_FRAME ? '0 : CUR_FRAME + FSEL_W'(1);
    framePrev = CUR_FRAME == '0 ? LAST_FRAME : CUR_FRAME - FSEL_W'(1);
  end

  always_ff @(posedge CLK or negedge IN_PB_RESET) begin
    if (!IN_PB_RESET) begin
      state <= WAIT;
      SRC_EN <= 1'b0;
      srcFrame <= '0;
      srcIdx <= '0;
      vramIdx <= '0;
      VRAM_EN <= 1'b0;
      GPU_DRAW <= 1'b0;
      KEY_IACK <= 1'b0;
      KEY_EN <= 1'b0;
      KEY_IEND <= 1'b0;
      keyCode <= '0;
      drawCount <= '0;
      CUR_FRAME <= '0;
      AUTO_MODE <= 1'b0;
    end else begin
      GPU_DRAW <= 1'b0;
      KEY_IACK <= 1'b0;
      KEY_EN <= 1'b0;
      KEY_IEND <= 1'b0;
      VRAM_EN <= state == COPY;
      case (state)
        WAIT: begin
          if (KEY_IRQ) begin
            KEY_IACK <= 1'b1;
            state <= KACK;
          end else if (GPU_READY) begin
            SRC_EN <= 1'b1;
            srcFrame <= CUR_FRAME;
            srcIdx <= '0;
            state <= COPY;
          end
        end
        COPY: begin
          vramIdx <= srcIdx;
          if (&srcIdx) begin
            SRC_EN <= 1'b0;
            state <= FLUSH;
          end else begin
            srcIdx <= srcIdx + FRAME_AW'(1);
          end
        end
        FLUSH: begin
          GPU_DRAW <= 1'b1;
          state <= DRAW;
        end
        DRAW: begin
          if (AUTO_MODE) begin
            drawCount <= drawCount == CNT_W'(AUTO_PERIOD - 1) ? '0 : drawCount + CNT_W'(1);
            CUR_FRAME <= drawCount == CNT_W'(AUTO_PERIOD - 1) ? frameNext : CUR_FRAME;
          end
          state <= WAIT;
        end
        KACK: begin
          KEY_EN <= 1'b1;
          state <= KRD;
        end
        KRD: state <= KLAT;
        KLAT: begin
          keyCode <= KEY_DATA;
          KEY_IEND <= 1'b1;
          state <= KDEC;
        end
        KDEC: begin
          if (isDigit) begin
            CUR_FRAME <= digitFrame;
            drawCount <= '0;
          end else if (keyCode == 16'h2B) begin
            CUR_FRAME <= frameNext;
          end else if (keyCode == 16'h2D) begin
            CUR_FRAME <= framePrev;
          end else if (keyCode == 16'h61) begin
            AUTO_MODE <= ~AUTO_MODE;
            drawCount <= '0;
          end
          state <= WAIT;
        end
        default: state <= WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_blit_sequencer.sv
// tb_frame_blit_sequencer: directed checks of copy timing, key decode, auto-animate and async reset
module tb_frame_blit_sequencer;
  logic clk = 1'b0;
  logic rstN = 1'b1;
  always #5 clk = ~clk;

  logic srcEnA, vramEnA, vramWriteA, gpuDrawA, keyIackA, keyEnA, keyIendA, autoA;
  logic [11:0] srcAddrA;
  logic [15:0] srcDataA = '0;
  logic [15:0] vramAddrA, vramDataA;
  logic [1:0] curFrameA;
  logic readyA = 1'b0, irqA = 1'b0;
  logic [15:0] keyCodeA = '0, keyDataA = '0;

  logic srcEnB, vramEnB, vramWriteB, gpuDrawB, keyIackB, keyEnB, keyIendB, autoB;
  logic [3:0] srcAddrB;
  logic [15:0] srcDataB = '0;
  logic [15:0] vramAddrB, vramDataB;
  logic [1:0] curFrameB;
  logic readyB = 1'b0, irqB = 1'b0;
  logic [15:0] keyCodeB = '0, keyDataB = '0;

  frame_blit_sequencer #(.AUTO_PERIOD(2)) dutA (
    .CLK(clk), .IN_PB_RESET(rstN), .SRC_EN(srcEnA), .SRC_ADDR(srcAddrA), .SRC_DATA(srcDataA),
    .VRAM_EN(vramEnA), .VRAM_WRITE(vramWriteA), .VRAM_ADDR(vramAddrA), .VRAM_DATA_W(vramDataA),
    .GPU_READY(readyA), .GPU_DRAW(gpuDrawA), .KEY_IRQ(irqA), .KEY_IACK(keyIackA), .KEY_EN(keyEnA),
    .KEY_DATA(keyDataA), .KEY_IEND(keyIendA), .CUR_FRAME(curFrameA), .AUTO_MODE(autoA));

  frame_blit_sequencer #(.NUM_FRAMES(3), .FRAME_AW(2), .AUTO_PERIOD(1)) dutB (
    .CLK(clk), .IN_PB_RESET(rstN), .SRC_EN(srcEnB), .SRC_ADDR(srcAddrB), .SRC_DATA(srcDataB),
    .VRAM_EN(vramEnB), .VRAM_WRITE(vramWriteB), .VRAM_ADDR(vramAddrB), .VRAM_DATA_W(vramDataB),
    .GPU_READY(readyB), .GPU_DRAW(gpuDrawB), .KEY_IRQ(irqB), .KEY_IACK(keyIackB), .KEY_EN(keyEnB),
    .KEY_DATA(keyDataB), .KEY_IEND(keyIendB), .CUR_FRAME(curFrameB), .AUTO_MODE(autoB));

  // Registered source RAM returns its own address; key RAM returns the pending code
  always @(posedge clk) begin
    if (srcEnA) srcDataA <= 16'(srcAddrA);
    if (keyEnA) keyDataA <= keyCodeA;
    if (keyEnB) keyDataB <= keyCodeB;
  end

  int total = 0, bad = 0;
  int cyc = 0, copyStart = 0, lastWr = 0, drawCyc = 0, draws = 0;
  int wrCount = 0, wrErr = 0, iackCyc = 0, enCyc = 0, iendCyc = 0;
  int iackN = 0, enN = 0, iendN = 0, keysA = 0;
  int copyFrame = 0, firstAddr = 0;
  logic prevSrcEn = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (srcEnA === 1'b1 && !prevSrcEn) begin
      copyStart = cyc;
      copyFrame = int'(srcAddrA[11:10]);
      firstAddr = int'(srcAddrA);
      wrCount = 0;
    end
    prevSrcEn = srcEnA === 1'b1;
    if (vramEnA === 1'b1) begin
      if (vramAddrA !== 16'(wrCount) || vramDataA !== 16'(copyFrame * 1024 + wrCount)) wrErr++;
      wrCount++;
      lastWr = cyc;
    end
    if (vramWriteA !== vramEnA) wrErr++;
    if (gpuDrawA === 1'b1) begin draws++; drawCyc = cyc; end
    if (keyIackA === 1'b1) begin iackN++; iackCyc = cyc; end
    if (keyEnA === 1'b1) begin enN++; enCyc = cyc; end
    if (keyIendA === 1'b1) begin iendN++; iendCyc = cyc; end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic waitDraw();
    int n0 = draws;
    int n = 0;
    while (draws == n0 && n < 1200) begin step(); n++; end
    checkVal("draw_seen", 32'(n < 1200), 1);
  endtask

  task automatic waitCopyStart();
    int n = 0;
    while (srcEnA !== 1'b1 && n < 50) begin step(); n++; end
    checkVal("copy_start", 32'(n < 50), 1);
  endtask

  task automatic sendKey(input int d, input logic [15:0] code);
    int n = 0;
    if (d == 0) begin keyCodeA = code; irqA = 1'b1; keysA++; end
    else begin keyCodeB = code; irqB = 1'b1; end
    while ((d == 0 ? keyIackA : keyIackB) !== 1'b1 && n < 40) begin step(); n++; end
    checkVal("iack_seen", 32'(n < 40), 1);
    irqA = 1'b0;
    irqB = 1'b0;
    n = 0;
    while ((d == 0 ? keyIendA : keyIendB) !== 1'b1 && n < 10) begin step(); n++; end
    checkVal("iend_seen", 32'(n < 10), 1);
    step();
    step();
  endtask

  int expF[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    #1 rstN = 1'b0;
    repeat (3) step();
    checkVal("rst_strobes", {srcEnA, vramEnA, vramWriteA, gpuDrawA, keyIackA, keyEnA, keyIendA}, 0);
    checkVal("rst_frame", curFrameA, 0);
    checkVal("rst_auto", autoA, 0);
    rstN = 1'b1;
    step();
    readyA = 1'b1;
    waitDraw();
    readyA = 1'b0;
    checkVal("copy0_frame", copyFrame, 0);
    checkVal("copy0_first", firstAddr, 0);
    checkVal("copy0_writes", wrCount, 1024);
    checkVal("copy0_wrerr", wrErr, 0);
    checkVal("copy0_len", lastWr - copyStart, 1024);
    checkVal("copy0_draw_gap", drawCyc - lastWr, 1);
    checkVal("copy0_draws", draws, 1);
    sendKey(0, 16'h33);
    checkVal("key_en_after_iack", enCyc - iackCyc, 1);
    checkVal("key_iend_after_en", iendCyc - enCyc, 2);
    checkVal("key33_frame", curFrameA, 2);
    readyA = 1'b1;
    waitDraw();
    readyA = 1'b0;
    checkVal("copy2_first", firstAddr, 'h800);
    checkVal("copy2_writes", wrCount, 1024);
    checkVal("copy2_wrerr", wrErr, 0);
    keyCodeA = 16'h31;
    readyA = 1'b1;
    waitCopyStart();
    repeat (100) step();
    irqA = 1'b1;
    keysA++;
    waitDraw();
    checkVal("midirq_frame", copyFrame, 2);
    checkVal("midirq_writes", wrCount, 1024);
    checkVal("midirq_wrerr", wrErr, 0);
    checkVal("midirq_cur", curFrameA, 2);
    begin
      int n = 0;
      while (keyIackA !== 1'b1 && n < 10) begin step(); n++; end
    end
    irqA = 1'b0;
    checkVal("midirq_iack_gap", iackCyc - drawCyc, 2);
    waitDraw();
    readyA = 1'b0;
    checkVal("midirq_next_frame", copyFrame, 0);
    checkVal("midirq_copy_after_iend", copyStart - iendCyc, 2);
    sendKey(0, 16'h61);
    checkVal("auto_on", autoA, 1);
    readyA = 1'b1;
    for (int i = 0; i < 9; i++) begin
      waitDraw();
      if (i == 8) readyA = 1'b0;
      checkVal($sformatf("auto_frame%0d", i), copyFrame, expF[i]);
    end
    sendKey(0, 16'h61);
    checkVal("auto_off", autoA, 0);
    readyA = 1'b1;
    waitDraw();
    waitDraw();
    readyA = 1'b0;
    checkVal("frozen_frame", copyFrame, 0);
    checkVal("frozen_cur", curFrameA, 0);
    sendKey(0, 16'h2D);
    checkVal("minus_wrap", curFrameA, 3);
    sendKey(0, 16'h2B);
    checkVal("plus_wrap", curFrameA, 0);
    sendKey(0, 16'h35);
    checkVal("digit_oob", curFrameA, 0);
    sendKey(0, 16'h34);
    checkVal("digit_last", curFrameA, 3);
    sendKey(0, 16'h32);
    checkVal("digit_one", curFrameA, 1);
    checkVal("iack_pulses", iackN, keysA);
    checkVal("en_pulses", enN, keysA);
    checkVal("iend_pulses", iendN, keysA);
    sendKey(1, 16'h33);
    checkVal("b_digit", curFrameB, 2);
    sendKey(1, 16'h2B);
    checkVal("b_plus_wrap", curFrameB, 0);
    sendKey(1, 16'h2D);
    checkVal("b_minus_wrap", curFrameB, 2);
    sendKey(1, 16'h34);
    checkVal("b_digit_oob", curFrameB, 2);
    sendKey(0, 16'h61);
    checkVal("auto_before_rst", autoA, 1);
    readyA = 1'b1;
    waitCopyStart();
    repeat (50) step();
    rstN = 1'b0;
    #1;
    checkVal("async_rst_strobes", {srcEnA, vramEnA, gpuDrawA}, 0);
    checkVal("async_rst_frame", curFrameA, 0);
    checkVal("async_rst_auto", autoA, 0);
    step();
    rstN = 1'b1;
    step();
    waitDraw();
    readyA = 1'b0;
    checkVal("post_rst_frame", copyFrame, 0);
    checkVal("post_rst_writes", wrCount, 1024);
    checkVal("post_rst_wrerr", wrErr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
